// File: rtl/comparador_serial_ctrl.sv
// Serial unsigned magnitude comparator: Z = (A > B).
// One comparison cell is stepped LSB first, one bit per clock.
module comparador_serial_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         Z
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  a_sr;
   logic [N-1:0]  b_sr;
   logic          p;
   logic [CW-1:0] cnt;

   logic ai;
   logic bi;
   logic p_cell;
   logic accept;
   logic last_bit;

   assign ai       = a_sr[0];
   assign bi       = b_sr[0];
   // A bit wins outright if Ai>Bi; on a tie the lower bits decide.
   assign p_cell   = (ai & ~bi) | (p & ~(ai ^ bi));
   assign accept   = (state != RUN) & start & ~abort;
   assign last_bit = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         p     <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Z     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  p     <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  p    <= p_cell;
                  a_sr <= a_sr >> 1;
                  b_sr <= b_sr >> 1;
                  if (last_bit) begin
                     Z     <= p_cell;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Directed bench for comparador_serial_ctrl (N=4).
module tb_comparador_serial_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic       Z;

   int n_checks = 0;
   int n_fails  = 0;

   comparador_serial_ctrl #(.N(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .abort (abort),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Z     (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic run_cmp(input string tag, input logic [3:0] a,
                          input logic [3:0] b, input logic exp_z);
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy"}, busy, 1'b1);
         check({tag, "_nodone"}, done, 1'b0);
         tick();
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_z"}, Z, exp_z);
      check({tag, "_idle"}, busy, 1'b0);
      tick();
      check({tag, "_done_off"}, done, 1'b0);
      check({tag, "_z_hold"}, Z, exp_z);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      A = '0;
      B = '0;
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_z", Z, 1'b0);
      reset = 1'b0;
      tick();

      run_cmp("c_vs_a", 4'b1100, 4'b1010, 1'b1);
      run_cmp("3_vs_5", 4'd3, 4'd5, 1'b0);
      run_cmp("9_vs_9", 4'd9, 4'd9, 1'b0);
      run_cmp("15_vs_0", 4'd15, 4'd0, 1'b1);

      // start and operand changes during RUN are ignored
      A = 4'd1;
      B = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      A = 4'd15;
      B = 4'd0;
      tick();
      start = 1'b0;
      check("ign_busy", busy, 1'b1);
      tick();
      check("ign_done", done, 1'b1);
      check("ign_z", Z, 1'b0);
      tick();
      check("ign_single", done, 1'b0);
      check("ign_idle", busy, 1'b0);
      tick();
      check("ign_nodone2", done, 1'b0);

      // start held high: one result every 5 cycles
      begin
         logic [3:0] va [4];
         logic [3:0] vb [4];
         logic       vz [4];
         va = '{4'd12, 4'd3, 4'd15, 4'd9};
         vb = '{4'd10, 4'd5, 4'd0, 4'd9};
         vz = '{1'b1, 1'b0, 1'b1, 1'b0};
         start = 1'b1;
         for (int k = 0; k < 4; k++) begin
            A = va[k];
            B = vb[k];
            tick();
            check("b2b_busy", busy, 1'b1);
            check("b2b_nodone", done, 1'b0);
            tick();
            tick();
            tick();
            check("b2b_busy4", busy, 1'b1);
            tick();
            check("b2b_done", done, 1'b1);
            check("b2b_z", Z, vz[k]);
         end
         start = 1'b0;
         tick();
         check("b2b_end_done", done, 1'b0);
         check("b2b_end_busy", busy, 1'b0);
      end

      // abort in the 3rd RUN cycle keeps the previous Z
      run_cmp("pre_abort", 4'd15, 4'd0, 1'b1);
      A = 4'd0;
      B = 4'd15;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_z", Z, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_nodone", done, 1'b0);
      end

      // abort beats start when idle
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", busy, 1'b0);
      tick();
      check("abort_start_busy2", busy, 1'b0);

      // asynchronous reset mid-RUN
      A = 4'd15;
      B = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_rst_busy", busy, 1'b1);
      check("pre_rst_z", Z, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_z", Z, 1'b0);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("arst_nodone", done, 1'b0);
         check("arst_nobusy", busy, 1'b0);
      end

      run_cmp("post_rst", 4'd5, 4'd4, 1'b1);
      run_cmp("msb_lose", 4'd7, 4'd8, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/comparador_serial_ctrl.md
COMPARADOR_SERIAL_CTRL -- requirements
Module: comparador_serial_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a comparison; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancel an operation in RUN.
REQ-006 The block SHALL have port A, input, N bits: first operand, captured on the accepting start edge.
REQ-007 The block SHALL have port B, input, N bits: second operand, captured on the accepting start edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while state is RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result completes.
REQ-010 The block SHALL have port Z, output, 1 bit: registered result, 1 iff A > B (unsigned).

Function
REQ-011 The block SHALL evaluate the comparison by stepping one typical cell right-to-left (LSB first), one bit per clock.
REQ-012 The per-bit cell SHALL compute P = (Ai & ~Bi) | (p & ~(Ai ^ Bi)), with p the carried bit from less significant bits.
REQ-013 The carried bit p SHALL be a register initialised to 0 on every accepted start.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: start=1 and abort=0 -> capture A, B into internal shift registers, clear p, clear bit counter, go RUN.
REQ-016 RUN: each edge processes bit index = counter, updates p <= P, increments counter.
REQ-017 RUN: on the edge processing bit N-1, Z <= P of that bit and state goes DONE.
REQ-018 DONE: lasts exactly one cycle; done=1 only in DONE; next state IDLE, or RUN if start=1 (back-to-back accepted, same capture rules as REQ-015).
REQ-019 Latency SHALL be fixed: done high in the cycle following the N-th edge after the start-sampling edge; no dependence on operand values.
REQ-020 start while in RUN SHALL be ignored; captured operands unaffected.
REQ-021 Changes on A and B after capture SHALL NOT affect the result in progress.
REQ-022 abort=1 in RUN SHALL return to IDLE on the next edge; no done pulse; Z keeps its previous value.
REQ-023 abort and start both high in IDLE or DONE: abort wins, start ignored, state goes IDLE.
REQ-024 Z SHALL change only on the edge of REQ-017 and hold between completions.
REQ-025 Counter SHALL be ceil(log2(N)) bits wide minimum and SHALL NOT wrap inside an operation.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, busy=0, done=0, Z=0, p=0, counter=0, operand registers 0, independent of clk.
REQ-027 reset asserted mid-RUN SHALL discard the operation; no done after release.
REQ-028 After reset deasserts, the first accepted start SHALL behave as REQ-015.

Verification (N=4)
REQ-029 A=4'b1100, B=4'b1010, start 1 cycle -> busy high 4 cycles, then done=1 for 1 cycle, Z=1.
REQ-030 A=4'd3, B=4'd5 -> Z=0 with done; then A=4'd9, B=4'd9 -> Z=0 (equality is not greater); A=4'd15, B=4'd0 -> Z=1.
REQ-031 start pulsed again 2 cycles into RUN, and A/B changed -> ignored; single done, Z from original operands.
REQ-032 start held high continuously, alternating operands -> done every 5 cycles (N RUN + 1 DONE), each Z correct.
REQ-033 abort in 3rd RUN cycle after prior result Z=1 -> IDLE next edge, no done, Z stays 1.
REQ-034 reset asserted between clock edges mid-RUN -> busy, done, Z go 0 immediately; no done after release.
